// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: source/line counts and the
// word offsets of the configuration registers.
package irq_pkg;

  localparam int NSRC    = 8;
  localparam int NLINE   = 5;
  localparam int NINT    = 6;
  localparam int ROUTE_W = 3;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ROUTE   = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;

endpackage

// File: rtl/irq_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous level inputs.
module irq_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes external sources, latches edge/level
// pending state, and routes masked sources onto the CP0 hardware lines.
module irq_ctrl #(
  parameter int NSRC  = irq_pkg::NSRC,
  parameter int NLINE = irq_pkg::NLINE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cfg_en,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic            cfg_ready,
  output logic [5:0]      int_o
);
  import irq_pkg::*;

  logic [NSRC-1:0]   s2;
  logic [NSRC-1:0]   s3;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   pending_nxt;
  logic [NSRC-1:0]   mask;
  logic [NSRC-1:0]   mode;
  logic [3*NSRC-1:0] route;
  logic [NSRC-1:0]   edge_det;
  logic [NSRC-1:0]   w1c;
  logic [1:0]        arm_cnt;
  logic              armed;
  logic [5:0]        int_nxt;
  logic [5:0]        int_p1;
  logic              req_wr;
  logic              req_rd;
  logic [31:0]       rd_mux;
  logic [31:0]       rdata_p1;
  logic              vld_p1;
  logic              unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:3*NSRC];

  irq_sync2 #(.WIDTH(NSRC)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_src),
    .q   (s2)
  );

  // Edge detection stays off until s1/s2/s3 all hold post-reset samples,
  // so a source already high at reset release is not seen as a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3      <= '0;
      arm_cnt <= 2'd0;
    end else begin
      s3 <= s2;
      if (arm_cnt != 2'd3)
        arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign armed    = (arm_cnt == 2'd3);
  assign edge_det = s2 & ~s3 & {NSRC{armed}};
  assign req_wr   = cfg_en & cfg_we;
  assign req_rd   = cfg_en & ~cfg_we;
  assign w1c      = (req_wr && cfg_addr == ADDR_PENDING) ? cfg_wdata[NSRC-1:0] : '0;

  // Edge bits: set wins over a simultaneous clear. Level bits track s2.
  assign pending_nxt = (mode & ((pending & ~w1c) | edge_det)) | (~mode & s2);

  always_comb begin
    int_nxt = '0;
    for (int k = 0; k < NLINE; k++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (pending[i] && mask[i] && route[ROUTE_W*i +: ROUTE_W] == ROUTE_W'(k))
          int_nxt[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      ADDR_PENDING: rd_mux = 32'(pending);
      ADDR_MASK:    rd_mux = 32'(mask);
      ADDR_MODE:    rd_mux = 32'(mode);
      ADDR_ROUTE:   rd_mux = 32'(route);
      ADDR_RAW:     rd_mux = 32'(s2);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      route   <= '0;
    end else begin
      pending <= pending_nxt;
      if (req_wr) begin
        case (cfg_addr)
          ADDR_MASK:  mask  <= cfg_wdata[NSRC-1:0];
          ADDR_MODE:  mode  <= cfg_wdata[NSRC-1:0];
          ADDR_ROUTE: route <= cfg_wdata[3*NSRC-1:0];
          default:    ;
        endcase
      end
    end
  end

  // ---- stage p1: registered interrupt lines and access response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      int_p1   <= '0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      int_p1   <= int_nxt;
      vld_p1   <= cfg_en;
      rdata_p1 <= req_rd ? rd_mux : '0;
    end
  end

  assign int_o     = int_p1;
  assign cfg_ready = vld_p1;
  assign cfg_rdata = rdata_p1;

endmodule
